// File: rtl/fifo_burst_arb_pkg.sv
// Shared types and helpers for the FIFO burst arbiter: FSM state encoding,
// channel-index width and burst eligibility/length rules.
package fifo_burst_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } arb_state_e;

  // Every module sizes channel indices as CH_W = chWidth(NUM_CH), i.e. $clog2(NUM_CH)
  function automatic int chWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

  function automatic logic burstEligible(input logic [31:0] count,
                                         input logic        flush,
                                         input logic [31:0] burstLen);
    return (count >= burstLen) || (flush && (count != 32'd0));
  endfunction

  // A flushing channel holding more than a full burst still gets a full burst
  function automatic logic [31:0] burstLength(input logic [31:0] count,
                                              input logic [31:0] burstLen);
    return (count >= burstLen) ? burstLen : count;
  endfunction

endpackage

// File: rtl/fifo_burst_arbiter_rr.sv
// Combinational round-robin picker: first requesting channel at or after
// rr_ptr_i, wrapping modulo NUM_CH.
module rr_arbiter
  import fifo_burst_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = chWidth(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   rr_ptr_i,
  output logic              gnt_valid_o,
  output logic [CH_W-1:0]   gnt_idx_o
);

  // Scan from the farthest offset down so the closest request wins last
  always_comb begin
    logic [CH_W-1:0] idx;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(rr_ptr_i) + k) % NUM_CH);
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_burst_arbiter.sv
// Shares one burst stream between NUM_CH channel FIFOs: round-robin grant,
// one length command per burst, then a pass-through drain of that many beats.
// Optional per-channel burst counters on stat_bursts when FIFO_ARB_STATS_EN is defined.
module fifo_burst_arbiter
  import fifo_burst_arb_pkg::*;
#(
  parameter  int NUM_CH    = 4,
  parameter  int DWIDTH    = 64,
  parameter  int AWIDTH    = 10,
  parameter  int BURST_LEN = 16,
  parameter  int LEN_WIDTH = 8,
  localparam int CH_W      = chWidth(NUM_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH*(AWIDTH+1)-1:0]  ch_data_count,
  input  logic [NUM_CH-1:0]             ch_flush,
  input  logic [NUM_CH-1:0]             ch_rvalid,
  output logic [NUM_CH-1:0]             ch_rready,
  input  logic [NUM_CH*DWIDTH-1:0]      ch_rdata,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic [CH_W-1:0]               cmd_ch,
  output logic [LEN_WIDTH-1:0]          cmd_len,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DWIDTH-1:0]             m_data,
  output logic                          m_last,
  output logic [CH_W-1:0]               m_ch,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]          stat_bursts
`endif
);

  localparam int CW = AWIDTH + 1;

  if (NUM_CH < 2 || NUM_CH > 16) begin : gBadNumCh
    $error("fifo_burst_arbiter: NUM_CH must be within 2..16");
  end
  if (BURST_LEN < 1 || longint'(BURST_LEN) > (longint'(1) << AWIDTH)) begin : gBadBurst
    $error("fifo_burst_arbiter: BURST_LEN must be within 1..2**AWIDTH");
  end
  if (longint'(BURST_LEN) - 1 >= (longint'(1) << LEN_WIDTH)) begin : gBadLenW
    $error("fifo_burst_arbiter: BURST_LEN-1 does not fit in LEN_WIDTH bits");
  end

  arb_state_e       state_q, state_d;
  logic [CH_W-1:0]  rrPtr_q, rrPtr_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [CW-1:0]    len_q, len_d;
  logic [CW-1:0]    beatCnt_q, beatCnt_d;

  logic [CW-1:0]     chCount [NUM_CH];
  logic [DWIDTH-1:0] chData  [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic              gntValid;
  logic [CH_W-1:0]   gntIdx;
  logic              lastBeat;
  logic              beatHs;

  for (genvar i = 0; i < NUM_CH; i++) begin : gCh
    assign chCount[i] = ch_data_count[i*CW +: CW];
    assign chData[i]  = ch_rdata[i*DWIDTH +: DWIDTH];
    assign req[i]     = burstEligible(32'(chCount[i]), ch_flush[i], 32'(BURST_LEN));
  end

  rr_arbiter #(.NUM_CH(NUM_CH)) uArb (
    .req_i       (req),
    .rr_ptr_i    (rrPtr_q),
    .gnt_valid_o (gntValid),
    .gnt_idx_o   (gntIdx)
  );

  assign lastBeat = (beatCnt_q == len_q - CW'(1));
  assign beatHs   = (state_q == DATA) && ch_rvalid[grant_q] && m_ready;

  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    grant_d   = grant_q;
    len_d     = len_q;
    beatCnt_d = beatCnt_q;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_len   = '0;
    m_valid   = 1'b0;
    m_data    = '0;
    m_last    = 1'b0;
    m_ch      = '0;
    ch_rready = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (gntValid) begin
          grant_d = gntIdx;
          len_d   = CW'(burstLength(32'(chCount[gntIdx]), 32'(BURST_LEN)));
          state_d = CMD;
        end
      end
      CMD: begin
        cmd_valid = 1'b1;
        cmd_ch    = grant_q;
        cmd_len   = LEN_WIDTH'(len_q - CW'(1));
        if (cmd_ready) begin
          state_d   = DATA;
          beatCnt_d = '0;
        end
      end
      DATA: begin
        // Zero-latency pass-through of the granted FIFO's read port
        m_valid            = ch_rvalid[grant_q];
        m_data             = chData[grant_q];
        m_ch               = grant_q;
        m_last             = lastBeat;
        ch_rready[grant_q] = m_ready;
        if (beatHs) begin
          beatCnt_d = beatCnt_q + CW'(1);
          if (lastBeat) begin
            state_d = IDLE;
            rrPtr_d = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      grant_q   <= '0;
      len_q     <= '0;
      beatCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      grant_q   <= grant_d;
      len_q     <= len_d;
      beatCnt_q <= beatCnt_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [31:0] statCnt_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) statCnt_q[i] <= '0;
    end else if (beatHs && lastBeat) begin
      statCnt_q[grant_q] <= statCnt_q[grant_q] + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : gStat
    assign stat_bursts[i*32 +: 32] = statCnt_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// Self-checking bench for fifo_burst_arbiter: FIFO environment, burst-level
// reference model compared every cycle, directed scenarios plus random traffic.
module tb_fifo_burst_arbiter;

  localparam int NUM_CH    = 4;
  localparam int DWIDTH    = 64;
  localparam int AWIDTH    = 10;
  localparam int BURST_LEN = 16;
  localparam int LEN_WIDTH = 8;
  localparam int CW        = AWIDTH + 1;
  localparam int CH_W      = 2;
  localparam int MEMD      = 4096;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [NUM_CH*CW-1:0]         ch_data_count = '0;
  logic [NUM_CH-1:0]            ch_flush = '0;
  logic [NUM_CH-1:0]            ch_rvalid = '0;
  logic [NUM_CH-1:0]            ch_rready;
  logic [NUM_CH*DWIDTH-1:0]     ch_rdata = '0;
  logic                         cmd_valid;
  logic                         cmd_ready = 1'b0;
  logic [CH_W-1:0]              cmd_ch;
  logic [LEN_WIDTH-1:0]         cmd_len;
  logic                         m_valid;
  logic                         m_ready = 1'b0;
  logic [DWIDTH-1:0]            m_data;
  logic                         m_last;
  logic [CH_W-1:0]              m_ch;
  logic                         busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NUM_CH*32-1:0]         stat_bursts;
`endif

  fifo_burst_arbiter #(
    .NUM_CH(NUM_CH), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH),
    .BURST_LEN(BURST_LEN), .LEN_WIDTH(LEN_WIDTH)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_data_count(ch_data_count), .ch_flush(ch_flush),
    .ch_rvalid(ch_rvalid), .ch_rready(ch_rready), .ch_rdata(ch_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_len(cmd_len),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .m_ch(m_ch), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stat_bursts(stat_bursts)
`endif
  );

  always #5 clk = ~clk;

  // FIFO environment: per-channel storage with head/tail indices
  logic [63:0] fifoMem [NUM_CH][MEMD];
  int  headIdx [NUM_CH];
  int  tailIdx [NUM_CH];
  bit  gate    [NUM_CH];
  bit  randMode = 1'b0;

  // Reference model: waiting (0), command offered (1), streaming (2)
  int mStage = 0, mCh = 0, mLen = 0, mBeats = 0, mPtr = 0;
  int unsigned mStats [NUM_CH];

  int  checks = 0, errors = 0, cycleNo = 0, curBeats = 0;
  bit  checkEn = 1'b0;
  int  cmdChLog[$], cmdLenLog[$], cmdCycLog[$], lastCycLog[$], lastAtLog[$];

  function automatic int fifoCount(input int i);
    return tailIdx[i] - headIdx[i];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic refreshInputs();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_data_count[i*CW +: CW] = CW'(fifoCount(i));
      ch_rvalid[i] = (fifoCount(i) > 0) && gate[i];
      ch_rdata[i*DWIDTH +: DWIDTH] = (fifoCount(i) > 0) ? fifoMem[i][headIdx[i] % MEMD] : 64'd0;
    end
  endtask

  task automatic pushData(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      fifoMem[ch][tailIdx[ch] % MEMD] = {32'(ch), 32'(tailIdx[ch])};
      tailIdx[ch]++;
    end
    refreshInputs();
  endtask

  task automatic clearLogs();
    cmdChLog.delete(); cmdLenLog.delete(); cmdCycLog.delete();
    lastCycLog.delete(); lastAtLog.delete();
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    if (randMode) begin
      cmd_ready = ($urandom_range(0, 3) != 0);
      m_ready   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NUM_CH; i++) begin
        ch_flush[i] = ($urandom_range(0, 7) == 0);
        gate[i]     = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 5) == 0 && fifoCount(i) < 900)
          pushData(i, int'($urandom_range(1, 4)));
      end
    end
    refreshInputs();
  endtask

  task automatic resetDut();
    applyStimulus();
    rst = 1'b1;
    ch_flush = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      headIdx[i] = tailIdx[i];
      gate[i]    = 1'b1;
    end
    refreshInputs();
    applyStimulus();
    rst = 1'b0;
    clearLogs();
    checkEn = 1'b1;
  endtask

  task automatic waitBursts(input int n, input int budget, input string name);
    int cyc = 0;
    while (lastAtLog.size() < n && cyc < budget) begin
      applyStimulus();
      cyc++;
    end
    if (lastAtLog.size() < n) checkOutput({name, "_timeout"}, 64'(lastAtLog.size()), 64'(n));
  endtask

  task automatic waitBeats(input int n, input int budget, input string name);
    int cyc = 0;
    while (curBeats < n && cyc < budget) begin
      applyStimulus();
      cyc++;
    end
    if (curBeats < n) checkOutput({name, "_timeout"}, 64'(curBeats), 64'(n));
  endtask

  // Reference model advances on each rising edge from the driven inputs
  initial forever begin
    @(posedge clk);
    cycleNo++;
    if (rst) begin
      mStage = 0; mPtr = 0; mCh = 0; mLen = 0; mBeats = 0;
      for (int i = 0; i < NUM_CH; i++) mStats[i] = 0;
    end else if (mStage == 0) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        int c, cnt;
        c   = (mPtr + k) % NUM_CH;
        cnt = int'(ch_data_count[c*CW +: CW]);
        if (cnt >= BURST_LEN || (ch_flush[c] && cnt != 0)) begin
          mCh    = c;
          mLen   = (cnt >= BURST_LEN) ? BURST_LEN : cnt;
          mStage = 1;
        end
      end
    end else if (mStage == 1) begin
      if (cmd_ready) begin
        mStage = 2;
        mBeats = 0;
      end
    end else if (ch_rvalid[mCh] && m_ready) begin
      headIdx[mCh]++;
      mBeats++;
      if (mBeats == mLen) begin
        mStats[mCh]++;
        mPtr   = (mCh + 1) % NUM_CH;
        mStage = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge
  initial forever begin
    @(negedge clk);
    #2;
    if (checkEn) begin
      checkOutput("busy",      64'(busy),      64'(mStage != 0));
      checkOutput("cmd_valid", 64'(cmd_valid), 64'(mStage == 1));
      checkOutput("cmd_ch",    64'(cmd_ch),    (mStage == 1) ? 64'(mCh) : 64'd0);
      checkOutput("cmd_len",   64'(cmd_len),   (mStage == 1) ? 64'(mLen - 1) : 64'd0);
      checkOutput("m_valid",   64'(m_valid),   (mStage == 2) ? 64'(ch_rvalid[mCh]) : 64'd0);
      checkOutput("m_ch",      64'(m_ch),      (mStage == 2) ? 64'(mCh) : 64'd0);
      checkOutput("m_last",    64'(m_last),    64'((mStage == 2) && (mBeats == mLen - 1)));
      checkOutput("m_data",    m_data,         (mStage == 2) ? ch_rdata[mCh*DWIDTH +: DWIDTH] : 64'd0);
      checkOutput("ch_rready", 64'(ch_rready), (mStage == 2 && m_ready) ? (64'd1 << mCh) : 64'd0);
`ifdef FIFO_ARB_STATS_EN
      for (int i = 0; i < NUM_CH; i++)
        checkOutput($sformatf("stat_bursts_%0d", i), 64'(stat_bursts[i*32 +: 32]), 64'(mStats[i]));
`endif
      if (cmd_valid && cmd_ready) begin
        cmdChLog.push_back(int'(cmd_ch));
        cmdLenLog.push_back(int'(cmd_len));
        cmdCycLog.push_back(cycleNo);
      end
      if (m_valid && m_ready) begin
        curBeats++;
        if (m_last) begin
          lastAtLog.push_back(curBeats);
          lastCycLog.push_back(cycleNo);
          curBeats = 0;
        end
      end
      if (rst) curBeats = 0;
    end
  end

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      headIdx[i] = 0; tailIdx[i] = 0; gate[i] = 1'b1; mStats[i] = 0;
    end

    // Single full burst on ch1
    resetDut();
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_cmd_valid", 64'(cmd_valid), 64'd0);
    cmd_ready = 1'b1; m_ready = 1'b1;
    pushData(1, 16);
    waitBursts(1, 100, "t1");
    checkOutput("t1_cmd_count", 64'(cmdChLog.size()), 64'd1);
    checkOutput("t1_cmd_ch",  64'((cmdChLog.size()  > 0) ? cmdChLog[0]  : -1), 64'd1);
    checkOutput("t1_cmd_len", 64'((cmdLenLog.size() > 0) ? cmdLenLog[0] : -1), 64'd15);
    checkOutput("t1_last_at", 64'((lastAtLog.size() > 0) ? lastAtLog[0] : -1), 64'd16);
    applyStimulus(); applyStimulus();
    #3;
    checkOutput("t1_idle_busy", 64'(busy), 64'd0);

    // Round robin over all channels, two non-data cycles between bursts
    resetDut();
    cmd_ready = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) pushData(i, 32);
    waitBursts(5, 400, "t2");
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t2_grant_%0d", k), 64'((cmdChLog.size() > k) ? cmdChLog[k] : -1), 64'(k % NUM_CH));
      checkOutput($sformatf("t2_last_at_%0d", k), 64'((lastAtLog.size() > k) ? lastAtLog[k] : -1), 64'd16);
    end
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t2_gap_%0d", k),
                  64'((cmdCycLog.size() > k + 1 && lastCycLog.size() > k) ? cmdCycLog[k+1] - lastCycLog[k] : -1),
                  64'd2);

    // Partial burst only released by flush
    resetDut();
    cmd_ready = 1'b1; m_ready = 1'b1;
    pushData(2, 5);
    repeat (10) applyStimulus();
    checkOutput("t3_no_grant", 64'(cmdChLog.size()), 64'd0);
    ch_flush = 4'b0100;
    waitBursts(1, 100, "t3");
    checkOutput("t3_cmd_ch",  64'((cmdChLog.size()  > 0) ? cmdChLog[0]  : -1), 64'd2);
    checkOutput("t3_cmd_len", 64'((cmdLenLog.size() > 0) ? cmdLenLog[0] : -1), 64'd4);
    checkOutput("t3_last_at", 64'((lastAtLog.size() > 0) ? lastAtLog[0] : -1), 64'd5);
    ch_flush = '0;

    // Delayed cmd_ready, toggling m_ready, FIFO valid stalls
    resetDut();
    cmd_ready = 1'b0; m_ready = 1'b0;
    pushData(3, 16);
    for (int cyc = 0; cyc < 300 && lastAtLog.size() < 1; cyc++) begin
      applyStimulus();
      cmd_ready = (cyc >= 4);
      m_ready   = cyc[0];
      gate[3]   = ($urandom_range(0, 3) != 0);
      refreshInputs();
    end
    checkOutput("t4_bursts", 64'(lastAtLog.size()), 64'd1);
    checkOutput("t4_cmd_ch",  64'((cmdChLog.size()  > 0) ? cmdChLog[0]  : -1), 64'd3);
    checkOutput("t4_last_at", 64'((lastAtLog.size() > 0) ? lastAtLog[0] : -1), 64'd16);
    gate[3] = 1'b1;

    // Reset mid-burst clears the round-robin pointer
    resetDut();
    cmd_ready = 1'b1; m_ready = 1'b1;
    pushData(1, 16);
    waitBursts(1, 100, "t5a");
    pushData(2, 16);
    waitBeats(7, 100, "t5b");
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    #3;
    checkOutput("t5_busy",      64'(busy),      64'd0);
    checkOutput("t5_cmd_valid", 64'(cmd_valid), 64'd0);
    checkOutput("t5_m_valid",   64'(m_valid),   64'd0);
    checkOutput("t5_ch_rready", 64'(ch_rready), 64'd0);
    clearLogs();
    pushData(0, 16);
    pushData(3, 16);
    waitBursts(1, 100, "t5c");
    checkOutput("t5_regrant_ch", 64'((cmdChLog.size() > 0) ? cmdChLog[0] : -1), 64'd0);

`ifdef FIFO_ARB_STATS_EN
    resetDut();
    cmd_ready = 1'b1; m_ready = 1'b1;
    pushData(1, 48);
    waitBursts(3, 300, "t6");
    applyStimulus();
    #3;
    checkOutput("t6_stat_ch1", 64'(stat_bursts[63:32]), 64'd3);
    checkOutput("t6_stat_ch0", 64'(stat_bursts[31:0]),  64'd0);
`endif

    // Random traffic against the model
    resetDut();
    randMode = 1'b1;
    repeat (3000) applyStimulus();
    randMode = 1'b0;
    repeat (5) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_arbiter.md
Name: fifo_burst_arbiter

Overview:
- Shares one downstream burst stream between NUM_CH channel sync FIFOs, e.g. the AXI write-data path fed by per-channel read FIFOs.
- Decides burst eligibility from each FIFO's data_count and picks a channel round-robin.
- Issues one length command per burst, then drains exactly that many beats from the chosen FIFO's read port.
- This block is the only reader of each FIFO.

Parameters:
- NUM_CH, 4: number of channel FIFOs, 2..16.
- DWIDTH, 64: FIFO and stream data width.
- AWIDTH, 10: FIFO address width. Each data_count is AWIDTH+1 bits.
- BURST_LEN, 16: full burst length in beats, 1..2**AWIDTH. Elaboration $error if out of range.
- LEN_WIDTH, 8: cmd_len width. Elaboration $error if BURST_LEN-1 >= 2**LEN_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ch_data_count  in  NUM_CH*(AWIDTH+1)  per-FIFO occupancy, channel i at slice i
- ch_flush  in  NUM_CH  channel may emit a partial final burst
- ch_rvalid  in  NUM_CH  FIFO read valid
- ch_rready  out  NUM_CH  FIFO read ready
- ch_rdata  in  NUM_CH*DWIDTH  FIFO read data
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  burst command accept
- cmd_ch  out  $clog2(NUM_CH)  granted channel
- cmd_len  out  LEN_WIDTH  beats-1, AXI style
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready
- m_data  out  DWIDTH  stream data
- m_last  out  1  final beat of the burst
- m_ch  out  $clog2(NUM_CH)  channel of the current beat
- busy  out  1  state != IDLE

Behaviour:
- Reset (sync, all registered state):
  - state=IDLE, rr_ptr=0, grant=0, beat_cnt=0.
  - Outputs: cmd_valid=0, m_valid=0, ch_rready=0, busy=0; cmd_ch, cmd_len, m_ch = 0.
- Eligibility of channel i:
  - eligible if count_i >= BURST_LEN, or (ch_flush[i] && count_i != 0).
- IDLE:
  - If any channel is eligible, pick the first eligible channel starting at rr_ptr, wrapping modulo NUM_CH.
  - Latch grant, and latch len = BURST_LEN if count >= BURST_LEN, else count.
  - Go to CMD next cycle.
  - If none is eligible, stay in IDLE.
  - A flush with count > BURST_LEN still yields a full BURST_LEN burst.
- CMD:
  - cmd_valid=1 with cmd_ch=grant and cmd_len=len-1, all held stable until cmd_ready.
  - On cmd_valid && cmd_ready, go to DATA with beat_cnt=0.
- DATA (zero-latency combinational pass-through):
  - m_valid = ch_rvalid[grant]; m_data = ch_rdata[grant]; m_ch = grant.
  - ch_rready[grant] = m_ready; all other ch_rready bits = 0.
  - m_last = (beat_cnt == len-1).
  - Each m_valid && m_ready handshake increments beat_cnt.
  - Handshake with m_last: go to IDLE, rr_ptr = grant+1 mod NUM_CH.
  - m_valid may drop mid-burst while the FIFO rvalid is low. The block then waits; no timeout.
- Channels not granted:
  - ch_rready stays 0 outside DATA.
  - FIFO occupancy can only grow while unread, so the latched len is always available.
- No overlap between bursts:
  - IDLE is spent between bursts, so back-to-back bursts cost 2 idle cycles (IDLE plus CMD without data).
- Eligibility and arbitration are evaluated only in IDLE. ch_flush/count changes during CMD or DATA take effect at the next IDLE.
- Reset mid-burst aborts to IDLE. Unread FIFO data is kept; downstream handles the truncated burst.
- Single-beat burst (len=1): m_last is high on the first beat.

Optional Feature:
- FIFO_ARB_STATS_EN defined:
  - Adds output stat_bursts, NUM_CH*32 bits.
  - Channel i's counter increments on its m_last handshake, wraps at 2**32, and resets to 0.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fifo_burst_arb_pkg holds:
  - state enum (IDLE, CMD, DATA);
  - the eligibility and length helper function;
  - the localparam CH_W = $clog2(NUM_CH) convention.
- Sub-module rr_arbiter (NUM_CH), combinational:
  - inputs: req vector, rr_ptr;
  - outputs: gnt_valid, gnt_idx.

Test Plan:
- Counts {0,16,0,0}, cmd_ready=1, m_ready=1 -> cmd ch1 len=15, then 16 beats with m_last on beat 16, then busy=0.
- All counts=32, continuous ready -> grants ch0,1,2,3,0 in order, each 16 beats, 2 idle cycles between bursts.
- ch2 count=5 with flush=0 -> no grant; raise flush -> cmd ch2 len=4, 5 beats, last on 5th.
- m_ready toggled 1/0 and cmd_ready delayed 3 cycles -> cmd payload stable, no beat lost or duplicated, ch_rready only on the granted channel.
- Reset asserted at beat 7 of a burst -> next cycle all outputs 0 and state IDLE; re-arbitration starts at ch0.
- FIFO_ARB_STATS_EN: 3 bursts on ch1 -> stat_bursts[1]=3, other channels 0.
